// File: rtl/hmac512_pkg.sv
// Shared types and constants for the HMAC/SHA-512 message path.
//   MsgFifoDepth : default entry count of the message FIFO
//   MsgFifoWidth : entry width in bits (64-bit data word + 8-bit byte mask)
//   sha_fifo_t   : one FIFO entry, mask in the upper byte, data below it
package hmac512_pkg;

    localparam int unsigned MsgFifoDepth = 16;
    localparam int unsigned MsgFifoWidth = 72;

    typedef struct packed {
        logic [7:0]  mask;
        logic [63:0] data;
    } sha_fifo_t;

endpackage

// File: rtl/sha512_msg_fifo_if.sv
// Handshake bundle for the SHA-512 message FIFO.
//   wvalid/wready/wdata : write side, entry accepted when wvalid & wready
//   rvalid/rready/rdata : read side, head consumed when rvalid & rready
//   master modport      : the party that writes entries and drains the head
//   slave modport       : the FIFO itself
interface sha512_msg_fifo_if #(
    parameter int unsigned Width = 72
);

    logic             wvalid;
    logic             wready;
    logic [Width-1:0] wdata;
    logic             rvalid;
    logic             rready;
    logic [Width-1:0] rdata;

    modport master (
        output wvalid, wdata, rready,
        input  wready, rvalid, rdata
    );

    modport slave (
        input  wvalid, wdata, rready,
        output wready, rvalid, rdata
    );

endinterface

// File: rtl/sha512_msg_fifo.sv
// First-word-fall-through message FIFO feeding the SHA-512 engine.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   clr_i                : synchronous flush (engine disabled); blocks both sides
//   wvalid_i/wready_o/wdata_i : write handshake and entry
//   rvalid_o/rready_i/rdata_o : read handshake and head entry (combinational)
//   depth_o              : current occupancy
//   full_o               : occupancy equals Depth
//   full_event_o         : one-cycle pulse when full_o rises
//   hwm_o                : highest occupancy since reset or last clear
module sha512_msg_fifo
    import hmac512_pkg::*;
#(
    parameter int unsigned Depth = MsgFifoDepth,
    parameter int unsigned Width = MsgFifoWidth
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    input  logic [Width-1:0]           wdata_i,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] depth_o,
    output logic                       full_o,
    output logic                       full_event_o,
    output logic [$clog2(Depth+1)-1:0] hwm_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [Width-1:0] storage [Depth];

    ptr_t wptr, rptr;
    ptr_t wptr_next, rptr_next;
    ptr_t depth_now, depth_next;
    ptr_t hwm;
    logic full, empty, full_next;
    logic do_write, do_read;
    logic full_event;

    // Flags and next-pointer computation. Pointers carry one extra wrap bit so
    // full (wrap bits differ, index equal) and empty (equal) are distinct.
    always_comb begin
        empty      = (wptr == rptr);
        full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        depth_now  = wptr - rptr;
        wready_o   = !full && !clr_i;
        rvalid_o   = !empty && !clr_i;
        do_write   = wvalid_i && wready_o;
        do_read    = rvalid_o && rready_i;
        wptr_next  = wptr + ptr_t'(do_write);
        rptr_next  = rptr + ptr_t'(do_read);
        if (clr_i) begin
            wptr_next = '0;
            rptr_next = '0;
        end
        depth_next = wptr_next - rptr_next;
        full_next  = (depth_next == ptr_t'(Depth));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr       <= '0;
            rptr       <= '0;
            hwm        <= '0;
            full_event <= 1'b0;
        end else begin
            wptr <= wptr_next;
            rptr <= rptr_next;
            if (clr_i) begin
                hwm <= '0;
            end else if (depth_next > hwm) begin
                hwm <= depth_next;
            end
            // Computed from next-state so the pulse lines up with full_o rising.
            full_event <= full_next && !full;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            storage[wptr[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o      = storage[rptr[AW-1:0]];
    assign depth_o      = depth_now;
    assign full_o       = full;
    assign full_event_o = full_event;
    assign hwm_o        = hwm;

    // A stalled writer must hold its offer until it is taken.
    writer_holds_offer: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (wvalid_i && !wready_o && !clr_i) |=> (wvalid_i && $stable(wdata_i))
    );

endmodule

// File: tb/tb_sha512_msg_fifo.sv
module tb_sha512_msg_fifo;
    import hmac512_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [4:0] depth;
    logic       full;
    logic       full_event;
    logic [4:0] hwm;

    sha512_msg_fifo_if #(.Width(72)) bus ();

    sha512_msg_fifo #(.Depth(16), .Width(72)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .wvalid_i     (bus.wvalid),
        .wready_o     (bus.wready),
        .wdata_i      (bus.wdata),
        .rvalid_o     (bus.rvalid),
        .rready_i     (bus.rready),
        .rdata_o      (bus.rdata),
        .depth_o      (depth),
        .full_o       (full),
        .full_event_o (full_event),
        .hwm_o        (hwm)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [71:0] model_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    function automatic logic [71:0] ent(input int unsigned k);
        sha_fifo_t e;
        e.mask = 8'(k * 37 + 1);
        e.data = 64'h0123_4567_0000_0000 ^ 64'(k) ^ (64'(k) << 40);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0;
        bus.wvalid = 1'b0; bus.rready = 1'b0; bus.wdata = '0;
        tick(); tick();
        n_cmp++; if (depth !== 5'd0) begin n_err++; $display("FAIL reset_depth got %0d want 0", depth); end
        n_cmp++; if (hwm !== 5'd0) begin n_err++; $display("FAIL reset_hwm got %0d want 0", hwm); end
        n_cmp++; if (full !== 1'b0 || full_event !== 1'b0) begin n_err++; $display("FAIL reset_full got %b/%b want 0/0", full, full_event); end
        n_cmp++; if (bus.rvalid !== 1'b0 || bus.wready !== 1'b1) begin n_err++; $display("FAIL reset_hs got rvalid=%b wready=%b want 0/1", bus.rvalid, bus.wready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        logic [71:0] exp;
        exp = {8'hFF, 64'h1122334455667788};
        bus.wdata = exp; bus.wvalid = 1'b1;
        #1;
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_err++; $display("FAIL no_passthrough rvalid got %b want 0", bus.rvalid); end
        tick();
        bus.wvalid = 1'b0;
        n_cmp++; if (bus.rvalid !== 1'b1) begin n_err++; $display("FAIL single_rvalid got %b want 1", bus.rvalid); end
        n_cmp++; if (bus.rdata !== exp) begin n_err++; $display("FAIL single_rdata got %h want %h", bus.rdata, exp); end
        n_cmp++; if (depth !== 5'd1) begin n_err++; $display("FAIL single_depth got %0d want 1", depth); end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        n_cmp++; if (depth !== 5'd0 || bus.rvalid !== 1'b0) begin n_err++; $display("FAIL single_drain got depth=%0d rvalid=%b want 0/0", depth, bus.rvalid); end
    endtask

    task automatic test_fill();
        int unsigned pulses;
        pulses = 0;
        model_q = {};
        for (int i = 0; i < 16; i++) begin
            bus.wdata = ent(i); bus.wvalid = 1'b1;
            tick();
            model_q.push_back(ent(i));
            if (full_event === 1'b1) pulses++;
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full); end
        n_cmp++; if (full_event !== 1'b1) begin n_err++; $display("FAIL fill_event_timing got %b want 1", full_event); end
        n_cmp++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL fill_wready got %b want 0", bus.wready); end
        n_cmp++; if (hwm !== 5'd16 || depth !== 5'd16) begin n_err++; $display("FAIL fill_hwm_depth got %0d/%0d want 16/16", hwm, depth); end
        // 17th entry offered while full
        bus.wdata = ent(17);
        tick();
        if (full_event === 1'b1) pulses++;
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL fill_event_count got %0d want 1", pulses); end
        n_cmp++; if (depth !== 5'd16) begin n_err++; $display("FAIL fill_17th_rejected depth got %0d want 16", depth); end
        n_cmp++; if (bus.rdata !== ent(0)) begin n_err++; $display("FAIL fill_head got %h want %h", bus.rdata, ent(0)); end
    endtask

    task automatic test_full_read_write();
        bus.rready = 1'b1;
        tick();
        void'(model_q.pop_front());
        bus.rready = 1'b0;
        n_cmp++; if (depth !== 5'd15) begin n_err++; $display("FAIL fullrw_depth got %0d want 15", depth); end
        n_cmp++; if (bus.rdata !== ent(1)) begin n_err++; $display("FAIL fullrw_head got %h want %h", bus.rdata, ent(1)); end
        n_cmp++; if (bus.wready !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL fullrw_ready got wready=%b full=%b want 1/0", bus.wready, full); end
        tick();
        model_q.push_back(ent(17));
        bus.wvalid = 1'b0;
        n_cmp++; if (depth !== 5'd16) begin n_err++; $display("FAIL fullrw_refill got %0d want 16", depth); end
        n_cmp++; if (full_event !== 1'b1) begin n_err++; $display("FAIL fullrw_event_again got %b want 1", full_event); end
        bus.rready = 1'b1;
        while (model_q.size() > 0) begin
            n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== model_q[0]) begin n_err++; $display("FAIL drain_order got %b/%h want 1/%h", bus.rvalid, bus.rdata, model_q[0]); end
            tick();
            void'(model_q.pop_front());
        end
        bus.rready = 1'b0;
        n_cmp++; if (depth !== 5'd0 || bus.rvalid !== 1'b0) begin n_err++; $display("FAIL drain_empty got depth=%0d rvalid=%b want 0/0", depth, bus.rvalid); end
    endtask

    task automatic test_back_to_back();
        int unsigned seq;
        seq = 100;
        bus.wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wdata = ent(seq);
            tick();
            model_q.push_back(ent(seq));
            seq++;
        end
        n_cmp++; if (depth !== 5'd5) begin n_err++; $display("FAIL b2b_prefill got %0d want 5", depth); end
        bus.rready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.wdata = ent(seq);
            #1;
            n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== model_q[0]) begin n_err++; $display("FAIL b2b_order cycle %0d got %b/%h want 1/%h", c, bus.rvalid, bus.rdata, model_q[0]); end
            tick();
            void'(model_q.pop_front());
            model_q.push_back(ent(seq));
            seq++;
            n_cmp++; if (depth !== 5'd5) begin n_err++; $display("FAIL b2b_depth cycle %0d got %0d want 5", c, depth); end
        end
        bus.wvalid = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic test_clear();
        bus.wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wdata = ent(200 + i);
            tick();
        end
        n_cmp++; if (depth !== 5'd9) begin n_err++; $display("FAIL clr_predepth got %0d want 9", depth); end
        clr = 1'b1;
        bus.wdata = ent(300);
        #1;
        n_cmp++; if (bus.wready !== 1'b0 || bus.rvalid !== 1'b0) begin n_err++; $display("FAIL clr_blocks got wready=%b rvalid=%b want 0/0", bus.wready, bus.rvalid); end
        tick();
        clr = 1'b0; bus.wvalid = 1'b0;
        model_q = {};
        n_cmp++; if (depth !== 5'd0 || hwm !== 5'd0) begin n_err++; $display("FAIL clr_zero got depth=%0d hwm=%0d want 0/0", depth, hwm); end
        n_cmp++; if (bus.rvalid !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL clr_flags got rvalid=%b full=%b want 0/0", bus.rvalid, full); end
        tick();
        n_cmp++; if (depth !== 5'd0) begin n_err++; $display("FAIL clr_offer_dropped depth got %0d want 0", depth); end
        bus.wvalid = 1'b1; bus.wdata = ent(400);
        tick();
        bus.wvalid = 1'b0;
        n_cmp++; if (depth !== 5'd1 || hwm !== 5'd1 || bus.rdata !== ent(400)) begin n_err++; $display("FAIL clr_after got depth=%0d hwm=%0d data=%h want 1/1/%h", depth, hwm, bus.rdata, ent(400)); end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.wvalid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.wdata = ent(500 + i);
            tick();
        end
        n_cmp++; if (depth !== 5'd7) begin n_err++; $display("FAIL arst_predepth got %0d want 7", depth); end
        bus.wdata = ent(507);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (depth !== 5'd0 || hwm !== 5'd0) begin n_err++; $display("FAIL arst_immediate got depth=%0d hwm=%0d want 0/0", depth, hwm); end
        n_cmp++; if (bus.rvalid !== 1'b0 || bus.wready !== 1'b1 || full !== 1'b0 || full_event !== 1'b0) begin n_err++; $display("FAIL arst_flags got rvalid=%b wready=%b full=%b fe=%b want 0/1/0/0", bus.rvalid, bus.wready, full, full_event); end
        bus.wvalid = 1'b0;
        tick(); tick();
        #2;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.rvalid !== 1'b0 || depth !== 5'd0) begin n_err++; $display("FAIL arst_no_spurious got rvalid=%b depth=%0d want 0/0", bus.rvalid, depth); end
        bus.wvalid = 1'b1; bus.wdata = ent(600);
        tick();
        bus.wvalid = 1'b0;
        n_cmp++; if (depth !== 5'd1 || bus.rvalid !== 1'b1 || bus.rdata !== ent(600)) begin n_err++; $display("FAIL arst_after got depth=%0d rvalid=%b data=%h want 1/1/%h", depth, bus.rvalid, bus.rdata, ent(600)); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_full_read_write();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
